// File: rtl/dcache_pkg.sv
// Shared request type and byte-merge helpers for the data-cache request queue.
package dcache_pkg;

  localparam int DC_ADDR_W = 32;
  localparam int DC_DATA_W = 32;
  localparam int DC_BE_W   = DC_DATA_W / 8;

  typedef struct packed {
    logic [DC_ADDR_W-1:0] addr;
    logic [DC_DATA_W-1:0] wdata;
    logic [DC_BE_W-1:0]   byteen;
  } dcache_req_t;

  typedef struct packed {
    logic [DC_DATA_W-1:0] data;
    logic [DC_BE_W-1:0]   be;
  } merge_result_t;

  // An all-zero byte-enable mask marks a load.
  function automatic logic is_store(input logic [DC_BE_W-1:0] byteen);
    return |byteen;
  endfunction

  function automatic merge_result_t merge_bytes(
    input logic [DC_DATA_W-1:0] old_data,
    input logic [DC_BE_W-1:0]   old_be,
    input logic [DC_DATA_W-1:0] new_data,
    input logic [DC_BE_W-1:0]   new_be
  );
    merge_result_t res;
    res.data = old_data;
    for (int b = 0; b < DC_BE_W; b++) begin
      if (new_be[b]) res.data[b*8 +: 8] = new_data[b*8 +: 8];
    end
    res.be = old_be | new_be;
    return res;
  endfunction

endpackage

// File: rtl/dcache_req_queue.sv
// In-order load/store queue in front of the data cache with fall-through,
// tail store coalescing, flush and occupancy status.
module dcache_req_queue
  import dcache_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = DC_ADDR_W,
  parameter int DATA_W       = DC_DATA_W,
  parameter int BE_W         = DATA_W / 8,
  parameter int FALL_THROUGH = 1,
  parameter int MERGE_EN     = 1,
  parameter int AF_THRESH    = DEPTH - 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [ADDR_W-1:0]          i_req_addr,
  input  logic [DATA_W-1:0]          i_req_wdata,
  input  logic [BE_W-1:0]            i_req_byteen,
  output logic                       o_cache_valid,
  input  logic                       i_cache_ready,
  output logic [ADDR_W-1:0]          o_cache_addr,
  output logic [DATA_W-1:0]          o_cache_wdata,
  output logic [BE_W-1:0]            o_cache_byteen,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic [BE_W-1:0]   mem_be    [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;

  logic is_empty;
  logic is_full;
  logic push;
  logic pop;
  logic pop_stored;
  logic bypass;
  logic do_merge;
  logic do_write;
  logic tail_store;
  logic same_word;

  logic [DATA_W-1:0] merged_data;
  logic [BE_W-1:0]   merged_be;

  assign tail_ptr = wr_ptr - 1'b1;
  assign is_empty = (count == '0);
  assign is_full  = (count == DEPTH_C);

  // Use the shared helpers when the widths line up with the package types.
  if (DATA_W == DC_DATA_W) begin : g_pkg_merge
    merge_result_t mres;
    assign mres        = merge_bytes(mem_wdata[tail_ptr], mem_be[tail_ptr],
                                     i_req_wdata, i_req_byteen);
    assign merged_data = mres.data;
    assign merged_be   = mres.be;
    assign tail_store  = is_store(mem_be[tail_ptr]);
  end else begin : g_generic_merge
    always_comb begin
      merged_data = mem_wdata[tail_ptr];
      for (int b = 0; b < BE_W; b++) begin
        if (i_req_byteen[b]) merged_data[b*8 +: 8] = i_req_wdata[b*8 +: 8];
      end
    end
    assign merged_be  = mem_be[tail_ptr] | i_req_byteen;
    assign tail_store = |mem_be[tail_ptr];
  end

  assign same_word = (mem_addr[tail_ptr][ADDR_W-1:OFF_W] == i_req_addr[ADDR_W-1:OFF_W]);

  always_comb begin
    o_req_ready    = !is_full && !i_flush && !i_rst;
    push           = i_req_valid && o_req_ready;
    o_cache_valid  = 1'b0;
    o_cache_addr   = mem_addr[rd_ptr];
    o_cache_wdata  = mem_wdata[rd_ptr];
    o_cache_byteen = mem_be[rd_ptr];
    if (!is_empty) begin
      o_cache_valid = !i_flush;
    end else if (FALL_THROUGH != 0) begin
      o_cache_valid  = push;
      o_cache_addr   = i_req_addr;
      o_cache_wdata  = i_req_wdata;
      o_cache_byteen = i_req_byteen;
    end
    pop        = o_cache_valid && i_cache_ready;
    pop_stored = pop && !is_empty;
    bypass     = (FALL_THROUGH != 0) && is_empty && push && pop;
    // Popping the only entry while coalescing into it would lose the new bytes.
    do_merge   = (MERGE_EN != 0) && push && (|i_req_byteen) && !is_empty &&
                 tail_store && same_word && !((count == ONE_C) && pop);
    do_write   = push && !do_merge && !bypass;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_stored) rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, pop_stored})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Entry storage has no reset; push is already blocked during reset and flush.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      mem_addr[wr_ptr]  <= i_req_addr;
      mem_wdata[wr_ptr] <= i_req_wdata;
      mem_be[wr_ptr]    <= i_req_byteen;
    end
    if (do_merge) begin
      mem_wdata[tail_ptr] <= merged_data;
      mem_be[tail_ptr]    <= merged_be;
    end
  end

  assign o_count       = count;
  assign o_empty       = is_empty;
  assign o_full        = is_full;
  assign o_almost_full = (count >= AF_C);

endmodule

// File: doc/dcache_req_queue.md
Name: dcache_req_queue

Overview:
Parametrised request queue between the LSU/memory stage and the data cache. It buffers loads and stores in program order and presents them to the cache with a valid/ready handshake. It replaces the fixed-width stall-based queue with these additions:
- configurable depth and width;
- optional fall-through bypass;
- store coalescing into the tail entry;
- flush;
- occupancy and almost-full status.

Parameters:
DEPTH, 8, entry count; power of two, at least 2
ADDR_W, 32, address width
DATA_W, 32, data width; multiple of 8
BE_W, DATA_W/8, byte-enable width (derived; do not override)
FALL_THROUGH, 1, 1 = an empty queue passes a request to the cache in the same cycle
MERGE_EN, 1, 1 = enable store coalescing into the tail entry
AF_THRESH, DEPTH-2, o_almost_full asserted when count >= AF_THRESH

Ports:
i_clk  in  1  clock; the only clock
i_rst  in  1  reset, synchronous, active-high
i_flush  in  1  discard all queued entries
i_req_valid  in  1  upstream request valid
o_req_ready  out  1  queue can accept a request
i_req_addr  in  ADDR_W  request byte address
i_req_wdata  in  DATA_W  store data
i_req_byteen  in  BE_W  store byte enables; all-zero = load
o_cache_valid  out  1  head request valid toward the cache
i_cache_ready  in  1  cache accepts the head this cycle
o_cache_addr  out  ADDR_W  head address
o_cache_wdata  out  DATA_W  head data
o_cache_byteen  out  BE_W  head byte enables
o_count  out  $clog2(DEPTH+1)  stored entries
o_empty  out  1  count == 0
o_full  out  1  count == DEPTH
o_almost_full  out  1  count >= AF_THRESH

Behaviour:
- Storage: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping naturally, plus a separate count register (full vs empty is decided by count, never by pointer equality).
- Reset, applied on the clock edge while i_rst is high:
  - pointers = 0, count = 0.
  - After reset: o_cache_valid = 0, o_empty = 1, o_full = 0, o_almost_full = 0, o_count = 0.
  - o_req_ready = 0 while i_rst is high.
- o_req_ready = !o_full && !i_flush && !i_rst. It has no combinational dependence on i_req_valid or i_cache_ready.
- push = i_req_valid && o_req_ready. pop = o_cache_valid && i_cache_ready.
- Head output:
  - count > 0: o_cache_* = entry[rd_ptr], o_cache_valid = 1.
  - count == 0 and FALL_THROUGH = 1: o_cache_* = i_req_*, o_cache_valid = push.
  - count == 0 and FALL_THROUGH = 0: o_cache_valid = 0. Minimum latency is one cycle.
- Bypass: when count == 0, FALL_THROUGH = 1, and push and pop occur together, nothing is written and count stays 0.
- Merge condition (all must hold): MERGE_EN = 1; push; i_req_byteen != 0; count >= 1; the tail entry is a store; tail addr[ADDR_W-1:$clog2(BE_W)] equals the incoming word address; and NOT (count == 1 && pop).
- On merge:
  - For each byte b with i_req_byteen[b] set, tail data byte b ← incoming byte.
  - Tail byteen ← tail byteen | i_req_byteen. The tail address is unchanged.
  - wr_ptr and count do not change on account of the push.
- Count update:
  - push (non-merge, non-bypass) only: +1.
  - pop only: -1.
  - Both: unchanged; write at wr_ptr, read at rd_ptr.
  - A merge together with a pop: -1.
- Loads never merge and are never reordered relative to stores. A load never overtakes an older store.
- Flush:
  - o_cache_valid is forced to 0 during the flush cycle, so no handshake occurs.
  - At the next edge: count = 0 and rd_ptr = wr_ptr = 0.
  - Requests presented during the flush cycle are not accepted.
- Reset overrides flush. Reset in mid-operation drops all entries with no output glitch after that edge.
- Status outputs are combinational from count.

Decomposition:
- dcache_pkg holds:
  - typedef dcache_req_t (addr, wdata, byteen), parametrised by the package constants DC_ADDR_W and DC_DATA_W;
  - function is_store(byteen);
  - function merge_bytes(old_data, old_be, new_data, new_be) returning {data, be}.
- No sub-module. The generic FIFO cannot expose write access to the tail entry, so storage, pointers and merge logic stay inline, in roughly 200 lines.

Test Plan:
1. Reset, then on the empty queue present a load at 0x100 with i_cache_ready = 1 and FALL_THROUGH = 1 → o_cache_valid = 1 in the same cycle with addr 0x100, and o_count remains 0.
2. Hold i_cache_ready = 0 and push 8 loads at 0x0, 0x4, … 0x1C → o_almost_full rises at count 6 and o_full at count 8, after which o_req_ready = 0. Release ready → pops come out in order 0x0 … 0x1C, and the pointers wrap cleanly on a second fill of 8.
3. Hold ready = 0 and push store 0x200 byteen 0x3 data 0x0000BEEF, then store 0x202 byteen 0xC data 0xCAFE0000 → count = 1 and the head shows byteen 0xF, data 0xCAFEBEEF.
4. Store 0x300, then load 0x300, then store 0x300, all with ready = 0 → count = 3 (the tail is a load, so no merge), and the pop order is store, load, store.
5. Count = 1 store at 0x400, push store 0x400 while pop occurs → no merge, and the next cycle count = 1 holding only the new store.
6. Count = 5, assert i_flush together with i_req_valid and i_cache_ready = 1 → no handshake on either side in that cycle, and the next cycle o_empty = 1 and o_count = 0.
